axil_config_bridge: RTL and testbench

- Upstream stage of the config splitter. Converts AXI4-Lite writes from the host shell into single-cycle config-interface write pulses (addr, data, valid).
- Performs range and strobe checking, and returns AXI responses.
- Config interface is write-only. AXI reads are answered with SLVERR.
- Output feeds the splitter's `in` port directly.

---
 rtl/axil_config_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_axil_config_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_config_bridge.sv
// AXI4-Lite to config-interface write bridge: turns accepted AXI writes into
// one-cycle cfg_valid pulses, answers reads with SLVERR, counts rejected accesses.
//
// state   | meaning
// W_IDLE  | collecting AW and W (either order or together)
// W_ISSUE | cfg_valid pulse for an accepted write
// W_RESP  | B response held until s_bready
// R_IDLE  | s_arready high, waiting for AR
// R_VALID | SLVERR read response held until s_rready
module axil_config_bridge #(
  parameter int AXIL_ADDR_WIDTH = 16,
  parameter int CFG_ADDR_WIDTH  = AXIL_ADDR_WIDTH - 2,
  parameter int ADDR_LIMIT      = 2 ** (AXIL_ADDR_WIDTH - 2),
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [31:0]                s_wdata,
  input  logic [3:0]                 s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [31:0]                s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [CFG_ADDR_WIDTH-1:0]  cfg_addr,
  output logic [31:0]                cfg_data,
  output logic                       cfg_valid,
  output logic [ERR_CNT_WIDTH-1:0]   err_count
);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_VALID} rd_state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [32:0] LIMIT_EXT   = 33'(ADDR_LIMIT);

  wr_state_t wr_state, wr_state_nx;
  rd_state_t rd_state, rd_state_nx;

  logic                      aw_captured, aw_cap_nx;
  logic                      w_captured, w_cap_nx;
  logic [CFG_ADDR_WIDTH-1:0] aw_word_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic                      awready_q, wready_q, arready_q;
  logic                      bvalid_q, rvalid_q;
  logic [1:0]                bresp_q, bresp_nx;
  logic [1:0]                rresp_q;
  logic                      cfg_valid_q, cfg_valid_nx;
  logic [CFG_ADDR_WIDTH-1:0] cfg_addr_q, cfg_addr_nx;
  logic [31:0]               cfg_data_q, cfg_data_nx;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q;
  logic [ERR_CNT_WIDTH:0]    err_sum;
  logic [1:0]                err_inc;
  logic                      wr_err;

  logic                      aw_hs, w_hs, ar_hs, r_hs;
  logic [CFG_ADDR_WIDTH-1:0] word_eff;
  logic [31:0]               wdata_eff;
  logic [3:0]                wstrb_eff;
  logic                      unused_inputs;

  // Valid/ready outputs are masked during reset so an in-flight write or
  // response is dropped in the very cycle reset is raised.
  assign s_awready = awready_q & ~rst;
  assign s_wready  = wready_q & ~rst;
  assign s_arready = arready_q & ~rst;
  assign s_bvalid  = bvalid_q & ~rst;
  assign s_rvalid  = rvalid_q & ~rst;
  assign cfg_valid = cfg_valid_q & ~rst;
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = '0;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign err_count = err_cnt_q;

  assign unused_inputs = ^{s_araddr, s_awaddr[1:0]};

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = s_rvalid & s_rready;

  assign word_eff  = aw_hs ? CFG_ADDR_WIDTH'(s_awaddr[AXIL_ADDR_WIDTH-1:2]) : aw_word_q;
  assign wdata_eff = w_hs ? s_wdata : wdata_q;
  assign wstrb_eff = w_hs ? s_wstrb : wstrb_q;

  always_comb begin
    wr_state_nx  = wr_state;
    aw_cap_nx    = aw_captured;
    w_cap_nx     = w_captured;
    bresp_nx     = bresp_q;
    cfg_valid_nx = 1'b0;
    cfg_addr_nx  = cfg_addr_q;
    cfg_data_nx  = cfg_data_q;
    wr_err       = 1'b0;
    case (wr_state)
      W_IDLE: begin
        aw_cap_nx = aw_captured | aw_hs;
        w_cap_nx  = w_captured | w_hs;
        if (aw_cap_nx && w_cap_nx) begin
          if (33'(word_eff) >= LIMIT_EXT) begin
            wr_state_nx = W_RESP;
            bresp_nx    = RESP_DECERR;
            wr_err      = 1'b1;
          end else if (wstrb_eff != 4'hF) begin
            wr_state_nx = W_RESP;
            bresp_nx    = RESP_SLVERR;
            wr_err      = 1'b1;
          end else begin
            wr_state_nx  = W_ISSUE;
            bresp_nx     = RESP_OKAY;
            cfg_valid_nx = 1'b1;
            cfg_addr_nx  = word_eff;
            cfg_data_nx  = wdata_eff;
          end
        end
      end
      W_ISSUE: wr_state_nx = W_RESP;
      W_RESP: begin
        if (s_bready) begin
          wr_state_nx = W_IDLE;
          aw_cap_nx   = 1'b0;
          w_cap_nx    = 1'b0;
        end
      end
      default: wr_state_nx = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nx = R_VALID;
      R_VALID: if (r_hs) rd_state_nx = R_IDLE;
      default: rd_state_nx = R_IDLE;
    endcase
  end

  // Write and read rejections can land on the same edge, hence a 2-bit step.
  always_comb begin
    err_inc = {1'b0, wr_err} + {1'b0, ar_hs};
    err_sum = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH+1)'(err_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state    <= W_IDLE;
      rd_state    <= R_IDLE;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      aw_word_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      wr_state    <= wr_state_nx;
      rd_state    <= rd_state_nx;
      aw_captured <= aw_cap_nx;
      w_captured  <= w_cap_nx;
      if (aw_hs) aw_word_q <= word_eff;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      // Readies follow the current state, so they reopen one cycle after
      // the B handshake rather than on it.
      awready_q   <= (wr_state == W_IDLE) && !aw_cap_nx;
      wready_q    <= (wr_state == W_IDLE) && !w_cap_nx;
      arready_q   <= (rd_state_nx == R_IDLE);
      bvalid_q    <= (wr_state_nx == W_RESP);
      rvalid_q    <= (rd_state_nx == R_VALID);
      bresp_q     <= bresp_nx;
      if (ar_hs) rresp_q <= RESP_SLVERR;
      cfg_valid_q <= cfg_valid_nx;
      cfg_addr_q  <= cfg_addr_nx;
      cfg_data_q  <= cfg_data_nx;
      err_cnt_q   <= err_sum[ERR_CNT_WIDTH] ? '1 : err_sum[ERR_CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_axil_config_bridge.sv
// Directed bench for axil_config_bridge with ADDR_LIMIT=16 and a 2-bit error counter.
module tb_axil_config_bridge;
  localparam int AW = 16;
  localparam int CW = 14;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_awaddr;
  logic          s_awvalid;
  logic          s_awready;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_wvalid;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid;
  logic          s_arready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready;
  logic [CW-1:0] cfg_addr;
  logic [31:0]   cfg_data;
  logic          cfg_valid;
  logic [EW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_config_bridge #(
    .AXIL_ADDR_WIDTH(AW),
    .CFG_ADDR_WIDTH (CW),
    .ADDR_LIMIT     (16),
    .ERR_CNT_WIDTH  (EW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .err_count(err_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    s_awaddr  = a;
    s_wdata   = d;
    s_wstrb   = s;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
  endtask

  task automatic test_reset;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
    s_bready = 1; s_araddr = '0; s_arvalid = 0; s_rready = 1;
    rst = 1;
    tick; tick;
    checks++;
    if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cfg_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids got %b exp 000000", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, cfg_valid});
    end
    checks++;
    if ({cfg_addr, cfg_data, s_bresp, s_rresp, s_rdata, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_values addr=%h data=%h bresp=%b rresp=%b rdata=%h err=%0d exp all 0",
               cfg_addr, cfg_data, s_bresp, s_rresp, s_rdata, err_count);
    end
    rst = 0;
    tick;
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_readies got %b exp 111", {s_awready, s_wready, s_arready});
    end
  endtask

  task automatic test_same_cycle;
    tick;
    start_write(16'h0010, 32'hDEADBEEF, 4'hF);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({cfg_valid, cfg_addr, cfg_data, s_bvalid} !== {1'b1, 14'd4, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL same_issue got v=%b a=%0d d=%h bv=%b exp v=1 a=4 d=deadbeef bv=0", cfg_valid, cfg_addr, cfg_data, s_bvalid);
    end
    checks++;
    if ({s_awready, s_wready} !== 2'b00) begin
      errors++;
      $display("FAIL same_ready_drop got %b exp 00", {s_awready, s_wready});
    end
    tick;
    checks++;
    if ({cfg_valid, s_bvalid, s_bresp, cfg_addr, err_count} !== {1'b0, 1'b1, 2'b00, 14'd4, 2'd0}) begin
      errors++;
      $display("FAIL same_resp got v=%b bv=%b br=%b a=%0d err=%0d exp v=0 bv=1 br=00 a=4 err=0",
               cfg_valid, s_bvalid, s_bresp, cfg_addr, err_count);
    end
    tick;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL same_bdone got bvalid=%b exp 0", s_bvalid);
    end
  endtask

  task automatic test_w_first;
    tick;
    s_wdata = 32'h1; s_wstrb = 4'hF; s_wvalid = 1;
    tick;
    s_wvalid = 0;
    checks++;
    if ({s_wready, s_awready, cfg_valid} !== 3'b010) begin
      errors++;
      $display("FAIL wfirst_wait got wr=%b awr=%b v=%b exp 0 1 0", s_wready, s_awready, cfg_valid);
    end
    tick; tick;
    s_awaddr = 16'h0008; s_awvalid = 1;
    tick;
    s_awvalid = 0;
    checks++;
    if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 14'd2, 32'h1}) begin
      errors++;
      $display("FAIL wfirst_issue got v=%b a=%0d d=%h exp v=1 a=2 d=1", cfg_valid, cfg_addr, cfg_data);
    end
    tick;
    checks++;
    if ({cfg_valid, s_bvalid, s_bresp} !== 4'b0100) begin
      errors++;
      $display("FAIL wfirst_resp got v=%b bv=%b br=%b exp 0 1 00", cfg_valid, s_bvalid, s_bresp);
    end
    tick;
  endtask

  task automatic test_decerr_boundary;
    tick;
    start_write(16'h0040, 32'h5, 4'hF);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({cfg_valid, s_bvalid, s_bresp, err_count} !== {1'b0, 1'b1, 2'b11, 2'd1}) begin
      errors++;
      $display("FAIL decerr got v=%b bv=%b br=%b err=%0d exp 0 1 11 1", cfg_valid, s_bvalid, s_bresp, err_count);
    end
    tick; tick;
    start_write(16'h003C, 32'h0A5A5A5A, 4'hF);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 14'd15, 32'h0A5A5A5A}) begin
      errors++;
      $display("FAIL limit_minus1 got v=%b a=%0d d=%h exp v=1 a=15 d=0a5a5a5a", cfg_valid, cfg_addr, cfg_data);
    end
    tick;
    checks++;
    if ({s_bvalid, s_bresp, err_count} !== {1'b1, 2'b00, 2'd1}) begin
      errors++;
      $display("FAIL limit_minus1_resp got bv=%b br=%b err=%0d exp 1 00 1", s_bvalid, s_bresp, err_count);
    end
    tick;
  endtask

  task automatic test_strobe_backpressure;
    tick;
    s_bready = 0;
    start_write(16'h0020, 32'h77, 4'h3);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({cfg_valid, s_bvalid, s_bresp, err_count} !== {1'b0, 1'b1, 2'b10, 2'd2}) begin
      errors++;
      $display("FAIL slverr got v=%b bv=%b br=%b err=%0d exp 0 1 10 2", cfg_valid, s_bvalid, s_bresp, err_count);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if ({s_bvalid, s_bresp, s_awready, s_wready, cfg_valid} !== 6'b110000) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got bv=%b br=%b awr=%b wr=%b v=%b exp 1 10 0 0 0",
                 i, s_bvalid, s_bresp, s_awready, s_wready, cfg_valid);
      end
    end
    s_bready = 1;
    tick;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got bvalid=%b exp 0", s_bvalid);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] pulses;
    pulses = '0;
    tick;
    start_write(16'h0014, 32'h12345678, 4'hF);
    for (int i = 0; i < 12; i++) begin
      tick;
      pulses[i] = cfg_valid;
    end
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (pulses !== 12'b0001_0001_0001) begin
      errors++;
      $display("FAIL b2b_pulses got %b exp 000100010001", pulses);
    end
    tick;
  endtask

  task automatic test_read_concurrent;
    rst = 1;
    tick;
    rst = 0;
    tick;
    s_rready = 0;
    s_arvalid = 1;
    start_write(16'h0080, 32'h9, 4'hF);
    tick;
    s_arvalid = 0; s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (err_count !== 2'd2) begin
      errors++;
      $display("FAIL err_plus2 got %0d exp 2", err_count);
    end
    checks++;
    if ({s_rvalid, s_rresp, s_rdata, s_arready, s_bvalid, s_bresp} !== {1'b1, 2'b10, 32'h0, 1'b0, 1'b1, 2'b11}) begin
      errors++;
      $display("FAIL rd_concurrent got rv=%b rr=%b rd=%h arr=%b bv=%b br=%b exp 1 10 0 0 1 11",
               s_rvalid, s_rresp, s_rdata, s_arready, s_bvalid, s_bresp);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b10, 32'h0}) begin
        errors++;
        $display("FAIL rd_hold cycle %0d got rv=%b rr=%b rd=%h exp 1 10 0", i, s_rvalid, s_rresp, s_rdata);
      end
    end
    s_rready = 1;
    tick;
    checks++;
    if ({s_rvalid, s_arready, err_count} !== {1'b0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL rd_done got rv=%b arr=%b err=%0d exp 0 1 2", s_rvalid, s_arready, err_count);
    end
  endtask

  task automatic test_saturation;
    s_arvalid = 1;
    tick;
    s_arvalid = 0;
    checks++;
    if (err_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_third got %0d exp 3", err_count);
    end
    tick;
    start_write(16'h0044, 32'h1, 4'hF);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if (err_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_fourth got %0d exp 3", err_count);
    end
    tick; tick;
    start_write(16'h0008, 32'h2, 4'h1);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({err_count, s_bresp} !== {2'd3, 2'b10}) begin
      errors++;
      $display("FAIL sat_fifth got err=%0d br=%b exp 3 10", err_count, s_bresp);
    end
    tick;
  endtask

  task automatic test_reset_mid_write;
    tick;
    start_write(16'h0004, 32'hCAFE0001, 4'hF);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    rst = 1;
    #1;
    checks++;
    if ({cfg_valid, s_bvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_abort_now got v=%b bv=%b exp 0 0", cfg_valid, s_bvalid);
    end
    tick;
    checks++;
    if ({cfg_valid, s_bvalid, s_awready, s_wready} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_abort got v=%b bv=%b awr=%b wr=%b exp 0000", cfg_valid, s_bvalid, s_awready, s_wready);
    end
    rst = 0;
    tick;
    checks++;
    if ({cfg_valid, s_bvalid, s_awready, s_wready} !== 4'b0011) begin
      errors++;
      $display("FAIL rst_recover got v=%b bv=%b awr=%b wr=%b exp 0011", cfg_valid, s_bvalid, s_awready, s_wready);
    end
    start_write(16'h000C, 32'h55AA55AA, 4'hF);
    tick;
    s_awvalid = 0; s_wvalid = 0;
    checks++;
    if ({cfg_valid, cfg_addr, cfg_data} !== {1'b1, 14'd3, 32'h55AA55AA}) begin
      errors++;
      $display("FAIL rst_new_issue got v=%b a=%0d d=%h exp v=1 a=3 d=55aa55aa", cfg_valid, cfg_addr, cfg_data);
    end
    tick;
    checks++;
    if ({s_bvalid, s_bresp} !== 3'b100) begin
      errors++;
      $display("FAIL rst_new_resp got bv=%b br=%b exp 1 00", s_bvalid, s_bresp);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_same_cycle;
    test_w_first;
    test_decerr_boundary;
    test_strobe_backpressure;
    test_back_to_back;
    test_read_concurrent;
    test_saturation;
    test_reset_mid_write;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule
